// File: rtl/nav_pkg.sv
// Shared types and constants for the obstacle-avoidance motion sequencer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package nav_pkg;

    // Encodings are shown on the 7-segment display, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROCEED = 3'd1,
        ST_TURN_L  = 3'd2,
        ST_TURN_R  = 3'd3,
        ST_HALT    = 3'd4,
        ST_BACKUP  = 3'd5
    } nav_state_t;

    // Motor driver direction pair encodings.
    localparam logic [1:0] MOT_FWD = 2'b01;
    localparam logic [1:0] MOT_REV = 2'b10;
    localparam logic [1:0] MOT_OFF = 2'b00;

    // Status LED patterns.
    localparam logic [7:0] LED_GO    = 8'hFF;
    localparam logic [7:0] LED_LEFT  = 8'hF0;
    localparam logic [7:0] LED_RIGHT = 8'h0F;
    localparam logic [7:0] LED_STOP  = 8'h00;
    localparam logic [7:0] LED_BACK  = 8'hAA;

    // Steer away from whichever side of the active pair is blocked.
    function automatic nav_state_t decide(input logic r, input logic l);
        nav_state_t s;
        case ({r, l})
            2'b00:   s = ST_PROCEED;
            2'b10:   s = ST_TURN_L;
            2'b01:   s = ST_TURN_R;
            default: s = ST_HALT;
        endcase
        return s;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/nav_debounce.sv
// Single-bit 2-flop synchronizer followed by a stability debouncer.
// Latency: output follows a stable input change after 2+DEB_CYCLES clocks.
// Backpressure: none; free-running per clock.
//
// Ports: clk, rst (sync, active-high), din (async input), dout (debounced).
// RST_VAL sets the value of every stage out of reset so a signal whose
// idle level is 1 does not produce a spurious edge after reset.
module nav_debounce #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            dout  <= RST_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Count consecutive cycles of disagreement; any agreement
            // (a glitch back to the old level) restarts the count.
            if (sync2 != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/nav_sequencer.sv
// Registered motion sequencer: debounced sensors -> proceed/turn/halt FSM -> motors/LEDs.
// Latency: sensor/dir edge to state change is 2+DEB_CYCLES+1 clocks; run to state is 1 clock.
// Backpressure: none; outputs are registered and update every clock.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   run               - 1 enables motion, 0 forces IDLE
//   dir_fwd           - commanded direction, 1 = forward
//   rfs/lfs/rrs/lrs   - obstacle sensors (right/left, front/rear), 1 = blocked
//   motor_l/motor_r   - motor direction pairs (01 fwd, 10 rev, 00 off)
//   leds              - 8-bit status pattern
//   state_code        - current state for the 7-segment display
//
// Optional build macro NAV_STALL_REVERSE_EN: a forward HALT that stays
// blocked for STALL_CYCLES backs up for TURN_CYCLES (state 5), then does a
// STOP_CYCLES hold before re-deciding. Without it HALT waits indefinitely.
module nav_sequencer
    import nav_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned TURN_CYCLES  = 32,
    parameter int unsigned STOP_CYCLES  = 8,
    parameter int unsigned STALL_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir_fwd,
    input  logic       rfs,
    input  logic       lfs,
    input  logic       rrs,
    input  logic       lrs,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic [7:0] leds,
    output logic [2:0] state_code
);

    localparam int unsigned CNT_MAX = max3(TURN_CYCLES, STOP_CYCLES, STALL_CYCLES);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
`ifdef NAV_STALL_REVERSE_EN
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_CYCLES - 1);
`endif

    // ---------------- input conditioning ----------------
    logic deb_rf, deb_lf, deb_rr, deb_lr, deb_dir;

    nav_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_rfs (
        .clk(clk), .rst(rst), .din(rfs), .dout(deb_rf));
    nav_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_lfs (
        .clk(clk), .rst(rst), .din(lfs), .dout(deb_lf));
    nav_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_rrs (
        .clk(clk), .rst(rst), .din(rrs), .dout(deb_rr));
    nav_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_lrs (
        .clk(clk), .rst(rst), .din(lrs), .dout(deb_lr));
    // Direction idles forward, so its debouncer comes out of reset at 1.
    nav_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_dir (
        .clk(clk), .rst(rst), .din(dir_fwd), .dout(deb_dir));

    // ---------------- state ----------------
    nav_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir_lat, dir_nxt;
    // Distinguishes the timed direction-change/back-up HALT from the
    // sensor-driven HALT; both share the same display code.
    logic          hold, hold_nxt;

    logic [1:0]    motor_l_nxt, motor_r_nxt, mot_d;
    logic [7:0]    leds_nxt;

    logic          act_r, act_l;   // active pair for the latched direction
    logic          new_r, new_l;   // active pair for the debounced direction
    logic [CW-1:0] cnt_inc;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_lat;
        hold_nxt  = hold;

        act_r   = dir_lat ? deb_rf : deb_rr;
        act_l   = dir_lat ? deb_lf : deb_lr;
        new_r   = deb_dir ? deb_rf : deb_rr;
        new_l   = deb_dir ? deb_lf : deb_lr;
        cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

        if (!run) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            hold_nxt  = 1'b0;
        end else if (state == ST_IDLE) begin
            dir_nxt   = deb_dir;
            state_nxt = decide(new_r, new_l);
            cnt_nxt   = '0;
        end else if (deb_dir != dir_lat) begin
            // Any direction change (including during a hold) restarts the hold.
            state_nxt = ST_HALT;
            dir_nxt   = deb_dir;
            hold_nxt  = 1'b1;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_PROCEED: begin
                    state_nxt = decide(act_r, act_l);
                    cnt_nxt   = '0;
                end
                ST_TURN_L, ST_TURN_R: begin
                    if (act_r && act_l) begin
                        state_nxt = ST_HALT;
                        cnt_nxt   = '0;
                    end else if (cnt >= TURN_LAST) begin
                        state_nxt = decide(act_r, act_l);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_HALT: begin
                    if (hold) begin
                        if (cnt >= STOP_LAST) begin
                            hold_nxt  = 1'b0;
                            state_nxt = decide(act_r, act_l);
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if (act_r && act_l) begin
`ifdef NAV_STALL_REVERSE_EN
                        if (dir_lat && (cnt >= STALL_LAST)) begin
                            state_nxt = ST_BACKUP;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
`else
                        cnt_nxt = '0;
`endif
                    end else begin
                        state_nxt = decide(act_r, act_l);
                        cnt_nxt   = '0;
                    end
                end
`ifdef NAV_STALL_REVERSE_EN
                ST_BACKUP: begin
                    // Sensors are ignored while reversing; only run and a
                    // direction change (handled above) cut this short.
                    if (cnt >= TURN_LAST) begin
                        state_nxt = ST_HALT;
                        hold_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    hold_nxt  = 1'b0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the registered outputs
        // always agree with the registered state_code.
        mot_d       = dir_nxt ? MOT_FWD : MOT_REV;
        leds_nxt    = LED_STOP;
        motor_l_nxt = MOT_OFF;
        motor_r_nxt = MOT_OFF;
        case (state_nxt)
            ST_PROCEED: begin
                leds_nxt    = LED_GO;
                motor_l_nxt = mot_d;
                motor_r_nxt = mot_d;
            end
            ST_TURN_L: begin
                leds_nxt    = LED_LEFT;
                motor_r_nxt = mot_d;
            end
            ST_TURN_R: begin
                leds_nxt    = LED_RIGHT;
                motor_l_nxt = mot_d;
            end
            ST_BACKUP: begin
                leds_nxt    = LED_BACK;
                motor_l_nxt = MOT_REV;
                motor_r_nxt = MOT_REV;
            end
            default: begin
                leds_nxt    = LED_STOP;
                motor_l_nxt = MOT_OFF;
                motor_r_nxt = MOT_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dir_lat    <= 1'b1;
            hold       <= 1'b0;
            motor_l    <= MOT_OFF;
            motor_r    <= MOT_OFF;
            leds       <= LED_STOP;
            state_code <= 3'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dir_lat    <= dir_nxt;
            hold       <= hold_nxt;
            motor_l    <= motor_l_nxt;
            motor_r    <= motor_r_nxt;
            leds       <= leds_nxt;
            state_code <= state_nxt;
        end
    end

endmodule

// File: tb/tb_nav_sequencer.sv
// Directed testbench for nav_sequencer with an expectation queue.
// Each stimulus step pushes the state/outputs/latency it should cause;
// the next observed state_code change pops and checks that entry.
module tb_nav_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       dir_fwd;
    logic       rfs, lfs, rrs, lrs;
    logic [1:0] motor_l, motor_r;
    logic [7:0] leds;
    logic [2:0] state_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] code;
        logic [7:0] leds;
        logic [1:0] ml;
        logic [1:0] mr;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    nav_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .dir_fwd(dir_fwd),
        .rfs(rfs), .lfs(lfs), .rrs(rrs), .lrs(lrs),
        .motor_l(motor_l), .motor_r(motor_r),
        .leds(leds), .state_code(state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference output model per state code and latched direction.
    task automatic push_exp(input logic [2:0] code, input bit fwd, input int lat);
        exp_t       e;
        logic [1:0] d;
        d = fwd ? 2'b01 : 2'b10;
        e.code = code;
        e.lat  = lat;
        case (code)
            3'd1:    begin e.leds = 8'hFF; e.ml = d;     e.mr = d;     end
            3'd2:    begin e.leds = 8'hF0; e.ml = 2'b00; e.mr = d;     end
            3'd3:    begin e.leds = 8'h0F; e.ml = d;     e.mr = 2'b00; end
            3'd5:    begin e.leds = 8'hAA; e.ml = 2'b10; e.mr = 2'b10; end
            default: begin e.leds = 8'h00; e.ml = 2'b00; e.mr = 2'b00; end
        endcase
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the next state_code change, then pop and compare.
    task automatic wait_change(input string tag, input int budget);
        logic [2:0] prev;
        int         n;
        bit         seen;
        exp_t       e;
        prev = state_code;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (state_code !== prev) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            chk({tag, ".timeout"}, 32'(0), 32'(1));
        end else begin
            chk({tag, ".code"}, 32'(state_code), 32'(e.code));
            chk({tag, ".leds"}, 32'(leds),       32'(e.leds));
            chk({tag, ".ml"},   32'(motor_l),    32'(e.ml));
            chk({tag, ".mr"},   32'(motor_r),    32'(e.mr));
            chk({tag, ".lat"},  32'(n),          32'(e.lat));
        end
    endtask

    // Confirms state_code stays at one value for a number of cycles.
    task automatic hold_steady(input string tag, input int cycles, input logic [2:0] code);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (state_code !== code) bad++;
        end
        chk(tag, 32'(bad), 32'(0));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; dir_fwd = 1'b1;
        rfs = 1'b0; lfs = 1'b0; rrs = 1'b0; lrs = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst.code", 32'(state_code), 32'(0));
        chk("rst.leds", 32'(leds),       32'(8'h00));
        chk("rst.ml",   32'(motor_l),    32'(2'b00));
        chk("rst.mr",   32'(motor_r),    32'(2'b00));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.code", 32'(state_code), 32'(0));

        // Start: clear road forward, debounced inputs already at rest values.
        run = 1'b1;
        push_exp(3'd1, 1'b1, 1);
        wait_change("start", 40);

        // Right-front block: turn left; released early, dwell still 32.
        rfs = 1'b1;
        push_exp(3'd2, 1'b1, 19);
        wait_change("turn_l", 40);
        repeat (5) @(negedge clk);
        rfs = 1'b0;
        push_exp(3'd1, 1'b1, 27);
        wait_change("turn_l_dwell", 60);

        // Short glitch is filtered by the debouncer.
        rfs = 1'b1;
        repeat (10) @(negedge clk);
        rfs = 1'b0;
        hold_steady("glitch", 40, 3'd1);

        // Direction change: 8-cycle HALT, then proceed in reverse.
        dir_fwd = 1'b0;
        push_exp(3'd4, 1'b0, 19);
        wait_change("dirchg_halt", 40);
        push_exp(3'd1, 1'b0, 8);
        wait_change("dirchg_rev", 20);

        // Rear pair is now active: left-rear block turns right.
        lrs = 1'b1;
        push_exp(3'd3, 1'b0, 19);
        wait_change("turn_r_rev", 40);
        // Both rear blocked pre-empts the turn dwell.
        rrs = 1'b1;
        push_exp(3'd4, 1'b0, 19);
        wait_change("rear_both", 40);
        rrs = 1'b0; lrs = 1'b0;
        push_exp(3'd1, 1'b0, 19);
        wait_change("rear_clear", 40);

        // Back to forward.
        dir_fwd = 1'b1;
        push_exp(3'd4, 1'b1, 19);
        wait_change("dirfwd_halt", 40);
        push_exp(3'd1, 1'b1, 8);
        wait_change("dirfwd_go", 20);

        // Both front blocked -> HALT; release left -> TURN_L; run=0 mid-turn.
        rfs = 1'b1; lfs = 1'b1;
        push_exp(3'd4, 1'b1, 19);
        wait_change("front_both", 40);
        lfs = 1'b0;
        push_exp(3'd2, 1'b1, 19);
        wait_change("halt_to_turn", 40);
        repeat (3) @(negedge clk);
        run = 1'b0;
        push_exp(3'd0, 1'b1, 1);
        wait_change("run_off", 10);
        run = 1'b1;
        push_exp(3'd2, 1'b1, 1);
        wait_change("run_on_turn", 10);
        rfs = 1'b0;
        push_exp(3'd1, 1'b1, 32);
        wait_change("fresh_dwell", 60);

        // Long blockage in HALT.
        rfs = 1'b1; lfs = 1'b1;
        push_exp(3'd4, 1'b1, 19);
        wait_change("stall_halt", 40);
`ifdef NAV_STALL_REVERSE_EN
        push_exp(3'd5, 1'b1, 64);
        wait_change("backup", 100);
        rfs = 1'b0; lfs = 1'b0;
        push_exp(3'd4, 1'b1, 32);
        wait_change("backup_done", 60);
        push_exp(3'd1, 1'b1, 8);
        wait_change("backup_hold", 20);
`else
        hold_steady("halt_persist", 120, 3'd4);
        rfs = 1'b0; lfs = 1'b0;
        push_exp(3'd1, 1'b1, 19);
        wait_change("halt_release", 40);
`endif

        // Reset mid-turn; debounced sensors restart at 0.
        rfs = 1'b1;
        push_exp(3'd2, 1'b1, 19);
        wait_change("pre_rst_turn", 40);
        rst = 1'b1;
        push_exp(3'd0, 1'b1, 1);
        wait_change("mid_rst", 10);
        rst = 1'b0;
        push_exp(3'd1, 1'b1, 1);
        wait_change("post_rst_go", 10);
        push_exp(3'd2, 1'b1, 18);
        wait_change("post_rst_turn", 40);

        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
